pong_ctrl: RTL and testbench
============================

Name: pong_ctrl

Overview:
- Game-control FSM at the far end of the pong graphics block's hit/miss/gra_still interface.
- Consumes per-pixel-clock hit/miss indications and the player buttons.
- Drives gra_still back to the graphics block.
- Maintains a two-digit BCD score, remaining-ball count and a frame-based hold timer, and exports status flags for the text overlay.

Parameters:
- BALLS, 3: balls per game, 1..3. Count reloads to BALLS-1 at game start.
- HOLD_TICKS, 127: refresh ticks to hold after a miss or at game over, 1..127 (about 2 s at 60 Hz).
- REFR_Y, 481: pix_y value that defines the refresh tick.

Ports:
- clk  in  1  pixel-domain clock
- reset  in  1  reset
- btn  in  2  player buttons, level, synchronous to clk
- pix_x  in  10  current pixel column from sync generator
- pix_y  in  10  current pixel row from sync generator
- hit  in  1  ball/paddle contact, level; may stay high for many cycles
- miss  in  1  ball passed right border, level
- gra_still  out  1  freeze/recentre ball and paddle
- show_title  out  1  high in NEWGAME
- show_over  out  1  high in OVER
- balls_left  out  2  remaining spare balls
- dig1  out  4  score tens, BCD
- dig0  out  4  score units, BCD

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk. All state is on posedge clk.
- Reset values:
  - state = NEWGAME, balls_left = BALLS-1, dig1/dig0 = 0/0
  - timer = 0, hit_d = 0
  - gra_still = 1, show_title = 1, show_over = 0
- Refresh tick: refr = (pix_y == REFR_Y) && (pix_x == 0). One clk per frame, combinational.
- Timer (7 bit):
  - Loaded with HOLD_TICKS by the state transitions below.
  - Otherwise decrements by 1 on refr while nonzero; holds at 0.
  - timer_done = (timer == 0).
- Hit edge:
  - hit_d registers hit every cycle.
  - hit_rise = hit & ~hit_d.
  - Only hit_rise counts, so one paddle contact scores exactly once.
- Score:
  - Two-digit BCD counter; +1 on hit_rise while in PLAY.
  - dig0 9 -> 0 carries into dig1.
  - 99 -> 00 wraps silently.
  - Synchronous clear on the NEWGAME -> PLAY transition.
- All outputs are registered-state decodes. gra_still = (state != PLAY).
- FSM:
  - NEWGAME
    - btn != 0 -> PLAY.
    - Same edge: clear score, balls_left = BALLS-1.
  - PLAY
    - miss, balls_left == 0 -> OVER, timer = HOLD_TICKS.
    - miss, balls_left != 0 -> NEWBALL, balls_left -= 1, timer = HOLD_TICKS.
    - Otherwise stay.
  - NEWBALL
    - timer_done && btn != 0 -> PLAY.
    - A button press before timer_done is ignored.
  - OVER
    - timer_done -> NEWGAME. No button is needed.
- Simultaneous hit_rise and miss in PLAY: miss wins; the score does not increment.
- hit or miss outside PLAY: ignored. hit_d still tracks hit.
- miss held high across the PLAY exit: acted on once only, because the state has left PLAY.
- Leaving NEWBALL: gra_still drops on the cycle after the button is sampled (one-cycle latency).
- Reset mid-game: immediate return to reset values; the score is lost.
- balls_left never underflows: decrement happens only when it is nonzero.

Decomposition:
- Package pong_pkg holds:
  - the state encoding (2-bit enum NEWGAME/PLAY/NEWBALL/OVER)
  - MAX_X = 640, MAX_Y = 480
  - the default REFR_Y
- Sub-module pong_bcd2:
  - two-digit BCD counter with clr and inc inputs, dig1/dig0 outputs, wrap at 99
  - reused later by the score-text renderer testbench
- Timer and FSM stay inline.

Test Plan:
- Reset release, no buttons -> gra_still = 1, show_title = 1, score 00, balls_left = 2; remains so for 3 frames.
- From NEWGAME, btn = 01 for one cycle -> next cycle PLAY, gra_still = 0, score 00, balls_left = 2.
- In PLAY, hit held high for 500 cycles, then low, repeated 12 times -> score 12 (dig1 = 1, dig0 = 2). Then preload 99 via 87 more hits -> wraps to 99 then 00 on the next hit.
- In PLAY with balls_left = 2, assert miss -> NEWBALL, balls_left = 1, gra_still = 1.
  - btn pressed at 100 refr ticks -> no change.
  - btn pressed after 127 ticks -> PLAY.
- Balls exhausted (balls_left = 0), assert miss -> OVER, show_over = 1. Exactly 127 refr ticks later -> NEWGAME with show_title = 1 and no button input.
- hit rising edge and miss in the same cycle with score 05 -> score stays 05 and the state leaves PLAY. Separately, async reset asserted mid-PLAY -> all reset values within the same cycle.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-control slice.
package pong_pkg;

    localparam int unsigned PIX_W      = 10;
    localparam int unsigned TIMER_W    = 7;
    localparam int unsigned BALLS_W    = 2;
    localparam int unsigned BTN_W      = 2;
    localparam int unsigned DIG_W      = 4;

    localparam int unsigned MAX_X      = 640;
    localparam int unsigned MAX_Y      = 480;
    localparam int unsigned REFR_Y_DEF = 481;

    typedef enum logic [1:0] {
        NEWGAME = 2'd0,
        PLAY    = 2'd1,
        NEWBALL = 2'd2,
        OVER    = 2'd3
    } state_e;

endpackage

// File: rtl/pong_bcd2.sv
// Two-digit BCD counter, clear has priority over increment, wraps 99 -> 00.
module pong_bcd2
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [DIG_W-1:0] dig1_o,
    output logic [DIG_W-1:0] dig0_o
);

    logic [DIG_W-1:0] dig1_q, dig1_d;
    logic [DIG_W-1:0] dig0_q, dig0_d;

    // Next-count: units roll into tens, tens roll silently to zero.
    always_comb begin
        dig1_d = dig1_q;
        dig0_d = dig0_q;
        if (clr_i) begin
            dig1_d = '0;
            dig0_d = '0;
        end else if (inc_i) begin
            if (dig0_q == DIG_W'(9)) begin
                dig0_d = '0;
                dig1_d = (dig1_q == DIG_W'(9)) ? '0 : dig1_q + DIG_W'(1);
            end else begin
                dig0_d = dig0_q + DIG_W'(1);
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig1_q <= '0;
            dig0_q <= '0;
        end else begin
            dig1_q <= dig1_d;
            dig0_q <= dig0_d;
        end
    end

    assign dig1_o = dig1_q;
    assign dig0_o = dig0_q;

endmodule

// File: rtl/pong_ctrl.sv
// Pong game-control FSM: score, spare balls, post-miss hold timer, overlay flags.
module pong_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned BALLS      = 3,
    parameter int unsigned HOLD_TICKS = 127,
    parameter int unsigned REFR_Y     = REFR_Y_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BTN_W-1:0]   btn,
    input  logic [PIX_W-1:0]   pix_x,
    input  logic [PIX_W-1:0]   pix_y,
    input  logic               hit,
    input  logic               miss,
    output logic               gra_still,
    output logic               show_title,
    output logic               show_over,
    output logic [BALLS_W-1:0] balls_left,
    output logic [DIG_W-1:0]   dig1,
    output logic [DIG_W-1:0]   dig0
);

    localparam logic [BALLS_W-1:0] BALLS_INIT = BALLS_W'(BALLS - 1);
    localparam logic [TIMER_W-1:0] HOLD_INIT  = TIMER_W'(HOLD_TICKS);

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [BALLS_W-1:0]   balls_q, balls_d;
    logic                 hit_q;
    logic                 score_clr, score_inc;
    logic                 refr, timer_done, hit_rise, btn_any;

    assign refr       = (pix_y == PIX_W'(REFR_Y)) && (pix_x == '0);
    assign timer_done = (timer_q == '0);
    assign hit_rise   = hit & ~hit_q;
    assign btn_any    = (btn != '0);

    // Next state, timer reload/countdown, ball count and score controls.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        balls_d   = balls_q;
        score_clr = 1'b0;
        score_inc = 1'b0;
        if (refr && !timer_done) begin
            timer_d = timer_q - TIMER_W'(1);
        end
        case (state_q)
            NEWGAME: begin
                if (btn_any) begin
                    state_d   = PLAY;
                    score_clr = 1'b1;
                    balls_d   = BALLS_INIT;
                end
            end
            PLAY: begin
                // A miss beats a simultaneous hit edge.
                if (miss) begin
                    timer_d = HOLD_INIT;
                    if (balls_q == '0) begin
                        state_d = OVER;
                    end else begin
                        state_d = NEWBALL;
                        balls_d = balls_q - BALLS_W'(1);
                    end
                end else if (hit_rise) begin
                    score_inc = 1'b1;
                end
            end
            NEWBALL: begin
                if (timer_done && btn_any) begin
                    state_d = PLAY;
                end
            end
            OVER: begin
                if (timer_done) begin
                    state_d = NEWGAME;
                end
            end
            default: state_d = NEWGAME;
        endcase
    end

    // State, timer, ball count and hit history registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= NEWGAME;
            timer_q <= '0;
            balls_q <= BALLS_INIT;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            balls_q <= balls_d;
            hit_q   <= hit;
        end
    end

    pong_bcd2 u_score (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (score_clr),
        .inc_i  (score_inc),
        .dig1_o (dig1),
        .dig0_o (dig0)
    );

    assign gra_still  = (state_q != PLAY);
    assign show_title = (state_q == NEWGAME);
    assign show_over  = (state_q == OVER);
    assign balls_left = balls_q;

endmodule

// File: tb/tb_pong_ctrl.sv
// Directed bench for pong_ctrl: vector table plus multi-cycle sequences.
module tb_pong_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn;
    logic [9:0] pix_x, pix_y;
    logic       hit, miss;
    logic       gra_still, show_title, show_over;
    logic [1:0] balls_left;
    logic [3:0] dig1, dig0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pong_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .hit        (hit),
        .miss       (miss),
        .gra_still  (gra_still),
        .show_title (show_title),
        .show_over  (show_over),
        .balls_left (balls_left),
        .dig1       (dig1),
        .dig0       (dig0)
    );

    typedef struct {
        logic [1:0] btn;
        logic       hit;
        logic       miss;
        logic       still;
        logic       title;
        logic       over;
        logic [1:0] balls;
        logic [3:0] d1;
        logic [3:0] d0;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic still, input logic title,
                           input logic over, input logic [1:0] balls,
                           input logic [3:0] d1, input logic [3:0] d0);
        logic [14:0] act, exp;
        act = {gra_still, show_title, show_over, balls_left, dig1, dig0};
        exp = {still, title, over, balls, d1, d0};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got still/title/over/balls/score = %b/%b/%b/%0d/%h%h, expected %b/%b/%b/%0d/%h%h",
                     nm, gra_still, show_title, show_over, balls_left, dig1, dig0,
                     still, title, over, balls, d1, d0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn = 2'b00; hit = 1'b0; miss = 1'b0;
        pix_x = 10'd5; pix_y = 10'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic refr_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            pix_y = 10'd481; pix_x = 10'd0;
            tick();
            pix_y = 10'd0; pix_x = 10'd5;
        end
    endtask

    task automatic press(input logic [1:0] b);
        btn = b;
        tick();
        btn = 2'b00;
    endtask

    task automatic one_hit();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        tick();
    endtask

    task automatic one_miss();
        miss = 1'b1;
        tick();
        miss = 1'b0;
    endtask

    initial begin
        //          btn    hit   miss  still title over balls d1 d0
        vecs[0] = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 4'd0, 4'd0};
        vecs[1] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0, 4'd0};
        vecs[2] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0, 4'd1};
        vecs[3] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0, 4'd1};
        vecs[4] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0, 4'd1};
        vecs[5] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0, 4'd2};
        vecs[6] = '{2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'd0, 4'd2};
        vecs[7] = '{2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'd0, 4'd2};
        vecs[8] = '{2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'd0, 4'd2};
        vecs[9] = '{2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'd0, 4'd2};

        // Reset state, held across three frames with no buttons.
        do_reset();
        chk_out("reset_values", 1, 1, 0, 2'd2, 4'd0, 4'd0);
        for (int f = 0; f < 3; f++) begin
            repeat (20) tick();
            refr_ticks(1);
        end
        chk_out("idle_3_frames", 1, 1, 0, 2'd2, 4'd0, 4'd0);

        // Cycle-by-cycle vector table from a fresh reset.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            btn  = vecs[i].btn;
            hit  = vecs[i].hit;
            miss = vecs[i].miss;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].still, vecs[i].title, vecs[i].over,
                    vecs[i].balls, vecs[i].d1, vecs[i].d0);
        end
        btn = 2'b00; hit = 1'b0; miss = 1'b0;

        // Long hit pulses count once each; then wrap through 99.
        do_reset();
        press(2'b01);
        chk_out("start_play", 0, 0, 0, 2'd2, 4'd0, 4'd0);
        for (int i = 0; i < 12; i++) begin
            hit = 1'b1;
            repeat (500) tick();
            hit = 1'b0;
            tick();
        end
        chk_out("score_12", 0, 0, 0, 2'd2, 4'd1, 4'd2);
        for (int i = 0; i < 87; i++) one_hit();
        chk_out("score_99", 0, 0, 0, 2'd2, 4'd9, 4'd9);
        one_hit();
        chk_out("score_wrap_00", 0, 0, 0, 2'd2, 4'd0, 4'd0);

        // Miss with spares left; button ignored until the hold timer expires.
        do_reset();
        press(2'b01);
        one_miss();
        chk_out("miss_to_newball", 1, 0, 0, 2'd1, 4'd0, 4'd0);
        refr_ticks(100);
        press(2'b01);
        chk_out("btn_early_ignored", 1, 0, 0, 2'd1, 4'd0, 4'd0);
        refr_ticks(27);
        tick();
        chk_out("newball_hold_done", 1, 0, 0, 2'd1, 4'd0, 4'd0);
        press(2'b10);
        chk_out("newball_to_play", 0, 0, 0, 2'd1, 4'd0, 4'd0);

        // Use the last spare, then game over and automatic return to title.
        one_miss();
        chk_out("last_spare_used", 1, 0, 0, 2'd0, 4'd0, 4'd0);
        refr_ticks(127);
        press(2'b01);
        chk_out("back_to_play_b0", 0, 0, 0, 2'd0, 4'd0, 4'd0);
        one_miss();
        chk_out("miss_to_over", 1, 0, 1, 2'd0, 4'd0, 4'd0);
        refr_ticks(126);
        chk_out("over_126_ticks", 1, 0, 1, 2'd0, 4'd0, 4'd0);
        refr_ticks(1);
        chk_out("over_127_ticks", 1, 0, 1, 2'd0, 4'd0, 4'd0);
        tick();
        chk_out("over_to_newgame", 1, 1, 0, 2'd0, 4'd0, 4'd0);
        press(2'b01);
        chk_out("restart_reload", 0, 0, 0, 2'd2, 4'd0, 4'd0);

        // Hit edge and miss together: miss wins, no score.
        do_reset();
        press(2'b01);
        for (int i = 0; i < 5; i++) one_hit();
        chk_out("score_05", 0, 0, 0, 2'd2, 4'd0, 4'd5);
        hit = 1'b1; miss = 1'b1;
        tick();
        hit = 1'b0; miss = 1'b0;
        chk_out("hit_miss_same_cycle", 1, 0, 0, 2'd1, 4'd0, 4'd5);

        // Asynchronous reset mid-play takes effect before the next edge.
        do_reset();
        press(2'b01);
        for (int i = 0; i < 3; i++) one_hit();
        one_miss();
        press(2'b01);
        refr_ticks(127);
        press(2'b01);
        chk_out("pre_async_reset", 0, 0, 0, 2'd1, 4'd0, 4'd3);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk_out("async_reset_immediate", 1, 1, 0, 2'd2, 4'd0, 4'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        chk_out("after_reset_release", 1, 1, 0, 2'd2, 4'd0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
